// File: rtl/fetch_prefetch_unit.sv
// Prefetching instruction front end: issues in-order word reads,
// buffers returns in a small FIFO and hands {pc, instr} to IF/ID.
module fetch_prefetch_unit #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            n_rst,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_addr_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = CW + OW + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [CW-1:0]   count;
  logic [OW-1:0]   outstanding;
  logic [OW-1:0]   out_next;
  logic [OW-1:0]   discard;
  logic            busy_discard;
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [XLEN-1:0] pc_mem  [DEPTH];
  logic [XLEN-1:0] ins_mem [DEPTH];

  logic [XLEN-1:0] target;
  logic [SW-1:0]   credit;
  logic            grant;
  logic            ret;
  logic            push;
  logic            pop;

  assign target = {redirect_pc_i[XLEN-1:2], 2'b00};

  // Reads already doomed by a redirect do not need FIFO space.
  assign credit = SW'(count) + SW'(outstanding)
                - SW'(discard);

  assign mem_req_o = n_rst && !redirect_i
                  && (outstanding < OW'(MAX_OUTSTANDING))
                  && (credit < SW'(DEPTH));
  assign mem_addr_o = fetch_pc;

  assign grant = mem_req_o && mem_gnt_i;
  assign ret   = mem_rvalid_i && (outstanding != '0);
  assign push  = ret && !busy_discard && !redirect_i;
  assign pop   = valid_o && ready_i && !redirect_i;

  assign out_next = outstanding + OW'(grant) - OW'(ret);

  assign valid_o = (count != '0);
  assign pc_o    = pc_mem[rptr];
  assign instr_o = ins_mem[rptr];

  always_ff @(posedge clk_i) begin
    if (!n_rst) begin
      fetch_pc     <= RESET_PC;
      resp_pc      <= RESET_PC;
      count        <= '0;
      outstanding  <= '0;
      discard      <= '0;
      busy_discard <= 1'b0;
      wptr         <= '0;
      rptr         <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]  <= '0;
        ins_mem[i] <= '0;
      end
    end else begin
      outstanding <= out_next;
      if (grant) begin
        fetch_pc <= fetch_pc + XLEN'(4);
      end
      if (redirect_i) begin
        fetch_pc     <= target;
        resp_pc      <= target;
        count        <= '0;
        wptr         <= '0;
        rptr         <= '0;
        discard      <= out_next;
        busy_discard <= (out_next != '0);
      end else begin
        if (ret && busy_discard) begin
          discard      <= discard - OW'(1);
          busy_discard <= (discard != OW'(1));
        end
        if (push) begin
          pc_mem[wptr]  <= resp_pc;
          ins_mem[wptr] <= mem_rdata_i;
          wptr          <= wptr + PW'(1);
          resp_pc       <= resp_pc + XLEN'(4);
        end
        if (pop) begin
          rptr <= rptr + PW'(1);
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  a_no_overflow: assert property (
    @(posedge clk_i) disable iff (!n_rst)
    !(push && !pop && (count == CW'(DEPTH))));

  a_outstanding: assert property (
    @(posedge clk_i) disable iff (!n_rst)
    outstanding <= OW'(MAX_OUTSTANDING));

endmodule
